// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory word-write port of the boot loader.
// The loader sits on the slave side; the byte source and memory sit on the master side.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  ByteValid;
  logic [7:0]            ByteData;
  logic                  Wr_En;
  logic [ADDR_WIDTH-1:0] Wr_Addr;
  logic [31:0]           Wr_Data;

  modport master (output ByteValid, ByteData, input Wr_En, Wr_Addr, Wr_Data);
  modport slave  (input ByteValid, ByteData, output Wr_En, Wr_Addr, Wr_Data);
endinterface

// File: rtl/instr_mem_loader.sv
// Parses a framed, XOR-checksummed program image from a byte stream into instruction
// memory, holding the CPU in reset until a verified image has been written.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [7:0]  START_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_WIDTH       = 20
) (
  input  logic              Clock,
  input  logic              SysReset,
  instr_mem_loader_if.slave bus,
  output logic              CpuReset_n,
  output logic              LoadDone,
  output logic              LoadError,
  output logic              Busy
);

  localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERROR} state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            csum_q, csum_d;
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           word_q, word_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic                  rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [TO_WIDTH-1:0]   to_q, to_d;

  logic                  start;
  logic [TO_WIDTH-1:0]   to_inc;
  logic [15:0]           n_hdr;

  assign start  = bus.ByteValid && (bus.ByteData == START_BYTE);
  assign to_inc = to_q + 1'b1;

  always_ff @(posedge Clock or negedge SysReset) begin
    if (!SysReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rst_n_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    word_d    = word_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    err_d     = err_q;
    busy_d    = busy_q;
    to_d      = to_q;
    n_hdr     = {bus.ByteData, cnt_q[7:0]};

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = CNT_LO;
          addr_d  = '0;
          csum_d  = '0;
          idx_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          rst_n_d = 1'b0;
          busy_d  = 1'b1;
          to_d    = '0;
        end
      end
      CNT_LO, CNT_HI, DATA, CHECK: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (bus.ByteValid) begin
          to_d = '0;
          case (state_q)
            CNT_LO: begin
              cnt_d   = {8'h00, bus.ByteData};
              state_d = CNT_HI;
            end
            CNT_HI: begin
              cnt_d = n_hdr;
              if (32'(n_hdr) > CAPACITY) begin
                state_d = ERROR;
                err_d   = 1'b1;
                busy_d  = 1'b0;
              end else if (n_hdr == 16'd0) begin
                state_d = CHECK;
              end else begin
                state_d = DATA;
              end
            end
            DATA: begin
              csum_d = csum_q ^ bus.ByteData;
              idx_d  = idx_q + 1'b1;
              case (idx_q)
                2'd0: word_d[7:0]   = bus.ByteData;
                2'd1: word_d[15:8]  = bus.ByteData;
                2'd2: word_d[23:16] = bus.ByteData;
                default: begin
                  wr_en_d   = 1'b1;
                  wr_data_d = {bus.ByteData, word_q};
                  wr_addr_d = addr_q;
                  addr_d    = addr_q + 1'b1;
                  cnt_d     = cnt_q - 1'b1;
                  if (cnt_q == 16'd1) state_d = CHECK;
                end
              endcase
            end
            default: begin
              if (bus.ByteData == csum_q) begin
                state_d = DONE;
                done_d  = 1'b1;
                rst_n_d = 1'b1;
              end else begin
                state_d = ERROR;
                err_d   = 1'b1;
              end
              busy_d = 1'b0;
            end
          endcase
        end else if (to_inc == TO_WIDTH'(TIMEOUT_CYCLES)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          rst_n_d = 1'b0;
        end else begin
          to_d = to_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Wr_En   = wr_en_q;
  assign bus.Wr_Addr = wr_addr_q;
  assign bus.Wr_Data = wr_data_q;
  assign CpuReset_n  = rst_n_q;
  assign LoadDone    = done_q;
  assign LoadError   = err_q;
  assign Busy        = busy_q;

endmodule
